// File: rtl/ecg_nn_pkg.sv
// rtl/ecg_nn_pkg.sv - shared types and layer constants for the ECG classifier
package ecg_nn_pkg;

    // 32-bit two's complement fixed-point activation
    typedef logic [31:0] act_t;

    // Defaults shared with the node generator so fan-in and latency agree
    localparam int ECG_N_IN     = 15;
    localparam int ECG_NODE_LAT = 3;

endpackage

// File: rtl/ecg_window_feeder_if.sv
// rtl/ecg_window_feeder_if.sv - sample input stream and result output stream of the feeder
interface ecg_window_feeder_if;
    import ecg_nn_pkg::*;

    act_t s_data;
    logic s_valid;
    logic s_first;
    logic s_ready;

    act_t r_data;
    logic r_valid;
    logic r_ready;

    // Environment side: produces samples, consumes results
    modport master (
        output s_data, s_valid, s_first,
        input  s_ready,
        input  r_data, r_valid,
        output r_ready
    );

    // Feeder side: consumes samples, produces results
    modport slave (
        input  s_data, s_valid, s_first,
        output s_ready,
        output r_data, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/ecg_window_feeder_lat_tag_pipe.sv
// rtl/ecg_window_feeder_lat_tag_pipe.sv - one-bit launch tag delay line producing the capture strobe
module lat_tag_pipe #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tag_in,
    output logic tag_out
);

    logic [DEPTH-1:0] tag_q;
    logic [DEPTH-1:0] tag_d;

    // Shift the tag one stage per edge; the last stage is the strobe
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Tag register; reset drops any launch still in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else begin
            tag_q <= tag_d;
        end
    end

    assign tag_out = tag_q[DEPTH-1];

endmodule

// File: rtl/ecg_window_feeder.sv
// rtl/ecg_window_feeder.sv - sliding-window driver and result collector for one ReLU node
module ecg_window_feeder
    import ecg_nn_pkg::*;
#(
    parameter int N_IN     = ECG_N_IN,
    parameter int STRIDE   = 1,
    parameter int NODE_LAT = ECG_NODE_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    ecg_window_feeder_if.slave    bus,
    output act_t                  A0x,
    output act_t                  A1x,
    output act_t                  A2x,
    output act_t                  A3x,
    output act_t                  A4x,
    output act_t                  A5x,
    output act_t                  A6x,
    output act_t                  A7x,
    output act_t                  A8x,
    output act_t                  A9x,
    output act_t                  A10x,
    output act_t                  A11x,
    output act_t                  A12x,
    output act_t                  A13x,
    output act_t                  A14x,
    input  act_t                  N1x
);

    localparam int              CW          = $clog2(N_IN + 1);
    localparam logic [CW-1:0]   FILL_FULL   = CW'(N_IN);
    // Counter value meaning "this accept completes a stride"
    localparam logic [CW-1:0]   STRIDE_LAST = CW'(STRIDE - 1);

    act_t          win_q [N_IN];
    act_t          win_d [N_IN];
    act_t          a_q   [N_IN];
    act_t          a_d   [N_IN];
    logic [CW-1:0] fill_q, fill_d;
    logic [CW-1:0] stride_cnt_q, stride_cnt_d;
    logic          inflight_q, inflight_d;
    logic          r_valid_q, r_valid_d;
    act_t          r_data_q, r_data_d;
    logic          s_ready;
    logic          accept;
    logic          fire;
    logic          capture;

    // Only one window in flight; a pending result also blocks input
    assign s_ready = !inflight_q && !r_valid_q;
    assign accept  = bus.s_valid && s_ready;

    // Window shift plus fill and stride bookkeeping on each accepted sample
    always_comb begin
        win_d        = win_q;
        fill_d       = fill_q;
        stride_cnt_d = stride_cnt_q;
        fire         = 1'b0;
        if (accept) begin
            for (int i = 0; i < N_IN - 1; i++) begin
                win_d[i] = win_q[i+1];
            end
            win_d[N_IN-1] = bus.s_data;

            // A new record restarts filling; old samples age out unseen
            if (bus.s_first) begin
                fill_d = CW'(1);
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end

            // The counter is preset by s_first and saturates while filling,
            // so the first full window always fires
            fire = (fill_d == FILL_FULL) &&
                   (bus.s_first || (stride_cnt_q == STRIDE_LAST));

            if (fire) begin
                stride_cnt_d = '0;
            end else if (bus.s_first) begin
                stride_cnt_d = STRIDE_LAST;
            end else if (stride_cnt_q != STRIDE_LAST) begin
                stride_cnt_d = stride_cnt_q + 1'b1;
            end
        end
    end

    // Launch tag delay matching the node pipeline
    lat_tag_pipe #(
        .DEPTH (NODE_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .reset   (reset),
        .tag_in  (fire),
        .tag_out (capture)
    );

    // Output window load, result capture and downstream handshake
    always_comb begin
        a_d        = a_q;
        inflight_d = inflight_q;
        r_valid_d  = r_valid_q;
        r_data_d   = r_data_q;
        if (r_valid_q && bus.r_ready) begin
            r_valid_d = 1'b0;
        end
        if (capture) begin
            r_valid_d  = 1'b1;
            r_data_d   = N1x;
            inflight_d = 1'b0;
        end
        if (fire) begin
            a_d        = win_d;
            inflight_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q        <= '{default: '0};
            a_q          <= '{default: '0};
            fill_q       <= '0;
            stride_cnt_q <= '0;
            inflight_q   <= 1'b0;
            r_valid_q    <= 1'b0;
            r_data_q     <= '0;
        end else begin
            win_q        <= win_d;
            a_q          <= a_d;
            fill_q       <= fill_d;
            stride_cnt_q <= stride_cnt_d;
            inflight_q   <= inflight_d;
            r_valid_q    <= r_valid_d;
            r_data_q     <= r_data_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.r_valid = r_valid_q;
    assign bus.r_data  = r_data_q;

    assign A0x  = a_q[0];
    assign A1x  = a_q[1];
    assign A2x  = a_q[2];
    assign A3x  = a_q[3];
    assign A4x  = a_q[4];
    assign A5x  = a_q[5];
    assign A6x  = a_q[6];
    assign A7x  = a_q[7];
    assign A8x  = a_q[8];
    assign A9x  = a_q[9];
    assign A10x = a_q[10];
    assign A11x = a_q[11];
    assign A12x = a_q[12];
    assign A13x = a_q[13];
    assign A14x = a_q[14];

endmodule

// File: tb/tb_ecg_window_feeder.sv
// tb/tb_ecg_window_feeder.sv - self-checking bench for ecg_window_feeder
module tb_ecg_window_feeder;
    import ecg_nn_pkg::*;

    localparam int N      = 15;
    localparam int STRIDE = 1;
    localparam int LAT    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ecg_window_feeder_if bus();
    act_t a_out [N];
    act_t n1x      = '0;
    act_t node_sum = '0;

    ecg_window_feeder #(
        .N_IN     (N),
        .STRIDE   (STRIDE),
        .NODE_LAT (LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .A0x   (a_out[0]),
        .A1x   (a_out[1]),
        .A2x   (a_out[2]),
        .A3x   (a_out[3]),
        .A4x   (a_out[4]),
        .A5x   (a_out[5]),
        .A6x   (a_out[6]),
        .A7x   (a_out[7]),
        .A8x   (a_out[8]),
        .A9x   (a_out[9]),
        .A10x  (a_out[10]),
        .A11x  (a_out[11]),
        .A12x  (a_out[12]),
        .A13x  (a_out[13]),
        .A14x  (a_out[14]),
        .N1x   (n1x)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // Bench node: sum of A then ReLU, two internal registers after the A outputs
    function automatic act_t sum_a();
        act_t s = '0;
        for (int i = 0; i < N; i++) s += a_out[i];
        return s;
    endfunction

    always @(posedge clk) begin
        node_sum <= sum_a();
        n1x      <= node_sum[31] ? '0 : node_sum;
    end

    // Behavioural reference: history of record samples, accepts since last fire
    act_t hist [$];
    int   since_fire    = 0;
    bit   first_pending = 1'b1;
    int   lat_cnt       = 0;
    bit   m_inflight    = 1'b0;
    bit   m_rvalid      = 1'b0;
    act_t m_rdata       = '0;
    act_t m_pend        = '0;
    act_t m_a [N];
    bit   started       = 1'b0;

    function automatic act_t relu_sum(input act_t w[$]);
        act_t s = '0;
        foreach (w[i]) s += w[i];
        return s[31] ? '0 : s;
    endfunction

    always @(posedge clk) begin : model
        bit acc;
        started = 1'b1;
        if (reset) begin
            hist.delete();
            since_fire    = 0;
            first_pending = 1'b1;
            lat_cnt       = 0;
            m_inflight    = 1'b0;
            m_rvalid      = 1'b0;
            m_rdata       = '0;
            for (int i = 0; i < N; i++) m_a[i] = '0;
        end else begin
            acc = bus.s_valid && !m_inflight && !m_rvalid;
            if (m_rvalid && bus.r_ready) m_rvalid = 1'b0;
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    m_rvalid   = 1'b1;
                    m_rdata    = m_pend;
                    m_inflight = 1'b0;
                end
            end
            if (acc) begin
                if (bus.s_first) begin
                    hist.delete();
                    first_pending = 1'b1;
                end
                hist.push_back(bus.s_data);
                if (hist.size() > N) void'(hist.pop_front());
                if (hist.size() == N && (first_pending || since_fire + 1 >= STRIDE)) begin
                    for (int i = 0; i < N; i++) m_a[i] = hist[i];
                    m_pend        = relu_sum(hist);
                    lat_cnt       = LAT;
                    m_inflight    = 1'b1;
                    first_pending = 1'b0;
                    since_fire    = 0;
                end else begin
                    since_fire++;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of handed-off results
    act_t got  [$];
    act_t gota [$];

    always @(negedge clk) begin
        if (started) begin
            check("s_ready", 32'(bus.s_ready), 32'(!m_inflight && !m_rvalid));
            check("r_valid", 32'(bus.r_valid), 32'(m_rvalid));
            check("r_data", bus.r_data, m_rdata);
            for (int i = 0; i < N; i++) check($sformatf("A%0dx", i), a_out[i], m_a[i]);
            if (bus.r_valid && bus.r_ready) begin
                got.push_back(bus.r_data);
                gota.push_back(a_out[0]);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic send(input act_t d, input bit f);
        int n = 0;
        bit rdy;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_first = f;
        forever begin
            @(negedge clk);
            rdy = bus.s_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                fail_now("send_wait");
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
    endtask

    // Counts negedges before r_valid is seen; returns on that negedge
    task automatic wait_rvalid(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.r_valid) break;
            n++;
            if (n > 50) begin
                fail_now("rvalid_wait");
                break;
            end
        end
    endtask

    task automatic take();
        @(posedge clk);
        #1;
        bus.r_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  seen;
        bit  done;
        bus.s_valid = 1'b0;
        bus.s_first = 1'b0;
        bus.s_data  = '0;
        bus.r_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_s_ready", 32'(bus.s_ready), 32'd1);
        check("reset_r_valid", 32'(bus.r_valid), 32'd0);
        check("reset_A0x", a_out[0], 32'd0);
        check("reset_r_data", bus.r_data, 32'd0);
        @(posedge clk);
        #1;

        // Basic window 1..15 and backpressure
        for (int k = 1; k <= 15; k++) send(act_t'(k), k == 1);
        wait_rvalid(n);
        check("basic_latency", 32'(n), 32'd3);
        check("basic_r_data", bus.r_data, 32'd120);
        check("basic_A0x", a_out[0], 32'd1);
        check("basic_A14x", a_out[14], 32'd15);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_r_data", bus.r_data, 32'd120);
            check("bp_s_ready", 32'(bus.s_ready), 32'd0);
        end
        take();
        @(negedge clk);
        check("bp_release_s_ready", 32'(bus.s_ready), 32'd1);
        check("bp_release_r_valid", 32'(bus.r_valid), 32'd0);
        @(posedge clk);
        #1;

        // ReLU clamps a negative sum
        for (int k = 0; k < 15; k++) send(32'hFFFF_FFFF, k == 0);
        wait_rvalid(n);
        check("relu_r_data", bus.r_data, 32'd0);
        check("relu_r_valid", 32'(bus.r_valid), 32'd1);
        take();

        // Stride 1 with downstream always ready
        got.delete();
        gota.delete();
        bus.r_ready = 1'b1;
        for (int k = 1; k <= 17; k++) send(act_t'(k), k == 1);
        repeat (10) @(posedge clk);
        #1;
        check("stride_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("stride_r0", got[0], 32'd120);
            check("stride_r1", got[1], 32'd135);
            check("stride_r2", got[2], 32'd150);
            check("stride_a0", gota[0], 32'd1);
            check("stride_a1", gota[1], 32'd2);
            check("stride_a2", gota[2], 32'd3);
        end

        // s_first mid-window restarts the fill
        got.delete();
        gota.delete();
        for (int k = 1; k <= 7; k++) send(act_t'(100 + k), k == 1);
        send(act_t'(201), 1'b1);
        for (int k = 2; k <= 14; k++) send(act_t'(200 + k), 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("restart_nofire", 32'(got.size()), 32'd0);
        send(act_t'(215), 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("restart_count", 32'(got.size()), 32'd1);
        if (got.size() == 1) begin
            check("restart_r_data", got[0], 32'd3120);
            check("restart_A0x", gota[0], 32'd201);
        end
        bus.r_ready = 1'b0;

        // Reset one edge after a fire drops the window
        for (int k = 0; k < 15; k++) send(act_t'(5), k == 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.r_valid) seen++;
        end
        check("rst_no_rvalid", 32'(seen), 32'd0);
        check("rst_A0x", a_out[0], 32'd0);
        check("rst_r_data", bus.r_data, 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Random traffic with random restarts and downstream stalls
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    int v;
                    int gap;
                    gap = int'($urandom_range(0, 2));
                    repeat (gap) begin
                        @(posedge clk);
                        #1;
                    end
                    v = int'($urandom_range(0, 2000)) - 1000;
                    send(act_t'(v), $urandom_range(0, 19) == 0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.r_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.r_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.r_ready = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
